// File: rtl/mux_nx1_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_nx1_scan : registered N:1 mux, direct select or round-robin auto-scan.
// Optional macro MUX_SCAN_MASK_EN adds skip_mask_i for scan stepping. Rev 1.0
// ---------------------------------------------------------------------------
module mux_nx1_scan #(
  parameter  int N    = 8,
  parameter  int W    = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    i_i,
  input  logic [SELW-1:0]   s_i,
  input  logic              mode_i,
  input  logic              load_i,
  input  logic              en_i,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]      skip_mask_i,
`endif
  output logic [W-1:0]      y_o,
  output logic [SELW-1:0]   y_sel_o,
  output logic              valid_o,
  output logic              wrap_o,
  output logic              err_o
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [W-1:0] ch [N];

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_ch
      assign ch[k] = i_i[k*W +: W];
    end
  endgenerate

  logic [W-1:0]    y_q, y_d;
  logic [SELW-1:0] y_sel_q, y_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;

  logic            step;
  logic [SELW-1:0] idx;
  logic            oor;
  logic [SELW-1:0] inc;
  logic [SELW-1:0] nxt;
  logic            nxt_wrap;
  logic            none_free;
`ifdef MUX_SCAN_MASK_EN
  logic            found;
  int              cand;
`endif

  always_comb begin
    step      = mode_i & ~load_i;
    idx       = step ? ptr_q : s_i;
    oor       = int'(idx) >= N;
    inc       = (idx == LAST) ? '0 : idx + 1'b1;
    nxt       = inc;
    nxt_wrap  = (idx == LAST);
    none_free = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    // First unmasked channel strictly after ptr, searching modulo N.
    nxt       = ptr_q;
    found     = 1'b0;
    cand      = 0;
    none_free = &skip_mask_i;
    for (int n = 1; n <= N; n++) begin
      cand = (int'(ptr_q) + n) % N;
      if (!found && !skip_mask_i[cand]) begin
        nxt   = SELW'(cand);
        found = 1'b1;
      end
    end
    nxt_wrap  = found && (nxt <= ptr_q);
`endif
  end

  always_comb begin
    y_d     = y_q;
    y_sel_d = y_sel_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (en_i) begin
      if (step && none_free) begin
        err_d = 1'b1;
      end else if (oor) begin
        y_d     = '0;
        y_sel_d = idx;
        valid_d = 1'b1;
        err_d   = 1'b1;
        ptr_d   = '0;
      end else begin
        y_d     = ch[idx];
        y_sel_d = idx;
        valid_d = 1'b1;
        if (!mode_i) begin
          ptr_d = idx;
        end else if (load_i) begin
          ptr_d  = inc;
          wrap_d = (idx == LAST);
        end else begin
          ptr_d  = nxt;
          wrap_d = nxt_wrap;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      y_sel_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      y_sel_q <= y_sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign y_o     = y_q;
  assign y_sel_o = y_sel_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;
  assign err_o   = err_q;

endmodule
`default_nettype wire
